// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage: ROM geometry, reset
// fetch address, the {pc, instr} fetch packet and the PC increment helper.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int PKT_W  = ADDR_W + DATA_W;

    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_pkt_t;

    // Sequential fetch address; wraps modulo 2^ADDR_W with no halt.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + 8'h01;
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch packets that absorbs the ROM's one-cycle read
// latency. Flush wins over push and pop; the head is read straight from
// storage registers so the consumer sees a registered value.
module fetch_skid_fifo
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_pkt_t push_pkt,
    output fetch_pkt_t head_pkt,
    output logic [1:0] count
);

    fetch_pkt_t mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       do_push_s;
    logic       do_pop_s;

    assign do_push_s = push & ~flush;
    assign do_pop_s  = pop & (count_r != 2'd0) & ~flush;
    assign head_pkt  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; flush empties the buffer in one edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= {PKT_W{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_pkt;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
        end
    end

endmodule

// File: rtl/fetch_skid_fifo_chk.sv
// Checker for the fetch skid FIFO: a push that is not matched by a pop
// must never land on a full buffer.
module fetch_skid_fifo_chk
    import cpu_pkg::*;
(
    input logic       clock,
    input logic       reset_n,
    input logic       push,
    input logic       pop,
    input logic       flush,
    input logic [1:0] count
);

    logic net_push_s;

    assign net_push_s = push & ~flush & ~(pop & (count != 2'd0));

    no_overflow_a : assert property (
        @(posedge clock) disable iff (!reset_n)
        !(net_push_s && (count == 2'd2))
    ) else $error("fetch_skid_fifo: push into full buffer");

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one synchronous ROM read per cycle when
// the skid buffer has room for its return, and hands {instr, pc} to decode
// over valid/ready. A redirect drops both buffered and in-flight fetches.
module instr_fetch_unit
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic              inflight_r;
    logic [ADDR_W-1:0] inflight_pc_r;

    logic [1:0]        count_s;
    fetch_pkt_t        head_s;
    fetch_pkt_t        push_pkt_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [2:0]        occupancy_s;

    assign instr_valid = (count_s != 2'd0);
    assign pop_s       = instr_valid & instr_ready;
    // A return is only kept if no redirect is discarding the stream this edge.
    assign push_s      = inflight_r & ~redirect_valid;
    assign push_pkt_s  = '{pc: inflight_pc_r, instr: rom_q};
    assign rom_address = fetch_pc_r;

    // Slots already claimed after this edge's pop; issue only if one is left
    // for the read that the ROM samples now.
    assign occupancy_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s     = (occupancy_s < 3'd2);

    // Decode-facing data, zeroed while the buffer is empty.
    always_comb begin
        instr    = {DATA_W{1'b0}};
        instr_pc = {ADDR_W{1'b0}};
        if (instr_valid) begin
            instr    = head_s.instr;
            instr_pc = head_s.pc;
        end else begin
            instr    = {DATA_W{1'b0}};
            instr_pc = {ADDR_W{1'b0}};
        end
    end

    // PC and in-flight tracking; redirect overrides issue in the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r    <= redirect_pc;
            inflight_r    <= 1'b0;
        end else if (issue_s) begin
            fetch_pc_r    <= next_pc(fetch_pc_r);
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
        end else begin
            inflight_r    <= 1'b0;
        end
    end

    fetch_skid_fifo u_skid (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push_s),
        .pop      (pop_s),
        .flush    (redirect_valid),
        .push_pkt (push_pkt_s),
        .head_pkt (head_s),
        .count    (count_s)
    );

    fetch_skid_fifo_chk u_skid_chk (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (redirect_valid),
        .count   (count_s)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural synchronous ROM.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [7:0]  rom_address;
    logic [31:0] rom_q;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    logic [31:0] rom_mem [256];
    int n_vec;
    int n_err;

    instr_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rom_address    (rom_address),
        .rom_q          (rom_q),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom_val(input logic [7:0] a);
        if (a == 8'h00) return 32'h01234567;
        if (a == 8'h01) return 32'h89ABCDEF;
        return {24'h0, a};
    endfunction

    initial begin
        for (int k = 0; k < 256; k++) rom_mem[k] = rom_val(k[7:0]);
        rom_q = 32'h0;
    end

    always @(posedge clock) rom_q <= rom_mem[rom_address];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold reset for two edges and release just after an edge.
    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        instr_ready = 1'b1;
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        step();
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
        n_vec++; if (instr_pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got=%h exp=00", instr_pc); end
        n_vec++; if (rom_address !== 8'h00) begin n_err++; $display("FAIL reset_addr got=%h exp=00", rom_address); end
    endtask

    task automatic test_startup();
        instr_ready = 1'b1;
        do_reset();
        step();
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL startup_early_valid got=%b exp=0", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (instr_valid !== 1'b1 || instr_pc !== i[7:0] || instr !== rom_val(i[7:0])) begin
                n_err++;
                $display("FAIL startup_seq[%0d] got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                         i, instr_valid, instr_pc, instr, i[7:0], rom_val(i[7:0]));
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        logic [7:0]  got_pc;
        logic [31:0] got_instr;
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr !== 32'h01234567) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got v=%b pc=%h i=%h exp v=1 pc=00 i=01234567", i, instr_valid, instr_pc, instr);
            end
            n_vec++;
            if (rom_address > 8'h02) begin
                n_err++;
                $display("FAIL bp_addr[%0d] got=%h exp<=02", i, rom_address);
            end
        end
        instr_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            if (instr_valid && instr_ready) begin
                got_pc = instr_pc;
                got_instr = instr;
                n_vec++;
                if (got_pc !== k[7:0] || got_instr !== rom_val(k[7:0])) begin
                    n_err++;
                    $display("FAIL bp_release[%0d] got pc=%h i=%h exp pc=%h i=%h", k, got_pc, got_instr, k[7:0], rom_val(k[7:0]));
                end
                k++;
            end
            step();
        end
        n_vec++; if (k != 6) begin n_err++; $display("FAIL bp_release_count got=%0d exp=6", k); end
    endtask

    task automatic test_redirect_inflight();
        instr_ready = 1'b1;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 8'h80;
        step();
        redirect_valid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got v=%b pc=%h exp v=0", instr_valid, instr_pc); end
        step();
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_stale got v=%b pc=%h exp v=0", instr_valid, instr_pc); end
        step();
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h80 || instr !== 32'h00000080) begin
            n_err++;
            $display("FAIL redir_first got v=%b pc=%h i=%h exp v=1 pc=80 i=00000080", instr_valid, instr_pc, instr);
        end
        step();
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h81 || instr !== 32'h00000081) begin
            n_err++;
            $display("FAIL redir_second got v=%b pc=%h i=%h exp v=1 pc=81 i=00000081", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc = '{8'hFF, 8'h00, 8'h01};
        exp_in = '{32'h000000FF, 32'h01234567, 32'h89ABCDEF};
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'hFF;
        step();
        redirect_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] || instr !== exp_in[i]) begin
                n_err++;
                $display("FAIL wrap[%0d] got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", i, instr_valid, instr_pc, instr, exp_pc[i], exp_in[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid got=%b exp=1", instr_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got=%b exp=0", instr_valid); end
        n_vec++; if (rom_address !== 8'h00) begin n_err++; $display("FAIL areset_addr got=%h exp=00", rom_address); end
        n_vec++; if (instr !== 32'h0 || instr_pc !== 8'h00) begin n_err++; $display("FAIL areset_data got i=%h pc=%h exp i=00000000 pc=00", instr, instr_pc); end
        step();
        reset_n = 1'b1;
        instr_ready = 1'b1;
        step();
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL areset_early_valid got=%b exp=0", instr_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (instr_valid !== 1'b1 || instr_pc !== i[7:0] || instr !== rom_val(i[7:0])) begin
                n_err++;
                $display("FAIL areset_seq[%0d] got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                         i, instr_valid, instr_pc, instr, i[7:0], rom_val(i[7:0]));
            end
        end
    endtask

    task automatic test_redirect_with_transfer();
        logic [7:0] log_pc [8];
        logic [7:0] exp_pc [3];
        int n;
        exp_pc = '{8'h01, 8'h10, 8'h11};
        instr_ready = 1'b1;
        do_reset();
        step();
        step();
        step();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            redirect_valid = (i == 0);
            redirect_pc = 8'h10;
            if (instr_valid && instr_ready && n < 8) begin
                log_pc[n] = instr_pc;
                n++;
            end
            step();
        end
        redirect_valid = 1'b0;
        n_vec++; if (n != 3) begin n_err++; $display("FAIL rt_count got=%0d exp=3", n); end
        for (int i = 0; i < 3; i++) begin
            if (i < n) begin
                n_vec++;
                if (log_pc[i] !== exp_pc[i]) begin
                    n_err++;
                    $display("FAIL rt_log[%0d] got pc=%h exp pc=%h", i, log_pc[i], exp_pc[i]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        instr_ready = 1'b0;
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_inflight();
        test_wrap();
        test_async_reset();
        test_redirect_with_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
